// File: rtl/nes_rom_loader_if.sv
// SDRAM write port used by the ROM loader.
//
// Handshake: the master raises mem_req with mem_addr/mem_din valid and keeps
// all three stable until the slave answers with a single-cycle mem_ack. The
// master drops mem_req in the cycle after mem_ack. Only one request is ever
// outstanding.
interface nes_rom_loader_if;
   logic        mem_req;
   logic [21:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_ack;

   modport master (output mem_req, mem_addr, mem_din, input mem_ack);
   modport slave  (input mem_req, mem_addr, mem_din, output mem_ack);
endinterface

// File: rtl/nes_rom_loader.sv
// nes_rom_loader: receives the iNES byte stream from the IO subsystem, parses
// the 16-byte header, skips an optional 512-byte trainer and writes PRG/CHR
// bytes to SDRAM through a single-outstanding req/ack port. A small FIFO of
// {addr, data} entries absorbs 4-byte bursts; each entry's address is decided
// when the byte is pushed.
//
// Optional feature macro: LOADER_NES20_EN (NES 2.0 mapper/bank extensions,
// widens mapper, prg_banks and chr_banks to 12 bits).
module nes_rom_loader #(
   parameter int          FIFO_DEPTH = 8,          // power of two, >= 4
   parameter logic [21:0] CHR_BASE   = 22'h200000
`ifdef LOADER_NES20_EN
   , localparam int FW = 12
`else
   , localparam int FW = 8
`endif
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                rom_loading,
   input  logic [7:0]          rom_do,
   input  logic                rom_do_valid,
   nes_rom_loader_if.master    bus,
   output logic                busy,
   output logic                done,
   output logic                header_valid,
   output logic [FW-1:0]       mapper,
   output logic [FW-1:0]       prg_banks,
   output logic [FW-1:0]       chr_banks,
   output logic [1:0]          mirroring,
   output logic                battery,
   output logic                error,
   output logic [2:0]          dbg_state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   // Byte counter wide enough for the largest PRG image (banks x 16 KB).
   localparam int CW = FW + 14;
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] BC_ONE   = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_TRAINER = 3'd2,
      S_PRG     = 3'd3,
      S_CHR     = 3'd4,
      S_DISCARD = 3'd5,
      S_DRAIN   = 3'd6
   } state_t;

   state_t          state;
   logic            load_q;
   logic            restart_pend;
   logic [3:0]      hdr_cnt;
   logic [8:0]      trn_cnt;
   logic [CW-1:0]   byte_cnt;
   logic            trainer;
`ifdef LOADER_NES20_EN
   logic            nes2;
`endif

   // FIFO storage and bookkeeping
   logic [29:0]     fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     fifo_cnt;
   logic [29:0]     head;

   logic            load_rise;
   logic            load_fall;
   logic            fall_evt;
   logic            restart_any;
   logic            start;
   logic            take;
   logic            prg_in_range;
   logic            push_req;
   logic [21:0]     push_addr;
   logic            fifo_full;
   logic            pop;
   logic            push_ok;
   logic            overflow;
   logic [CW-1:0]   prg_last;
   logic [CW-1:0]   chr_last;

   assign dbg_state = state;
   assign head      = fifo_mem[rd_ptr];

   // Next data section after the header/trainer: PRG, then CHR, else discard.
   function automatic state_t next_data(input logic [FW-1:0] p, input logic [FW-1:0] c);
      if (p != '0)      return S_PRG;
      else if (c != '0) return S_CHR;
      else              return S_DISCARD;
   endfunction

   // Edge detection, restart arbitration and per-byte push decision.
   always_comb begin
      load_rise    = rom_loading & ~load_q;
      load_fall    = ~rom_loading & load_q;
      fall_evt     = load_fall && (state != S_IDLE);
      restart_any  = restart_pend || (load_rise && (state != S_IDLE));
      // A restart waits for the in-flight write to be acknowledged.
      start        = (state == S_IDLE && load_rise) ||
                     (restart_any && (!bus.mem_req || bus.mem_ack));
      take         = rom_do_valid && !restart_any && !load_fall;
      prg_in_range = (byte_cnt[CW-1:21] == '0);
      prg_last     = {prg_banks, 14'd0} - BC_ONE;
      chr_last     = {1'b0, chr_banks, 13'd0} - BC_ONE;
      push_req     = take && ((state == S_PRG && prg_in_range) || state == S_CHR);
      push_addr    = (state == S_CHR) ? (CHR_BASE + byte_cnt[21:0]) : byte_cnt[21:0];
      fifo_full    = (fifo_cnt == CNT_FULL);
      pop          = !bus.mem_req && (fifo_cnt != '0) && !restart_any;
      push_ok      = push_req && (!fifo_full || pop);
      overflow     = push_req && fifo_full && !pop;
   end

   // FIFO entry write; the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= {push_addr, rom_do};
   end

   // FIFO pointers; a restart flushes every queued entry.
   always_ff @(posedge clk) begin
      if (!resetn || restart_any) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: ;
         endcase
      end
   end

   // Write port: launch the FIFO head when idle, hold it until acknowledged.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_din  <= '0;
      end else if (bus.mem_req && bus.mem_ack) begin
         bus.mem_req  <= 1'b0;
      end else if (pop) begin
         bus.mem_req  <= 1'b1;
         bus.mem_addr <= head[29:8];
         bus.mem_din  <= head[7:0];
      end
   end

   // Load sequencer: header parse, section counting, drain and restart.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= S_IDLE;
         load_q       <= 1'b0;
         restart_pend <= 1'b0;
         hdr_cnt      <= '0;
         trn_cnt      <= '0;
         byte_cnt     <= '0;
         trainer      <= 1'b0;
`ifdef LOADER_NES20_EN
         nes2         <= 1'b0;
`endif
         busy         <= 1'b0;
         done         <= 1'b0;
         header_valid <= 1'b0;
         mapper       <= '0;
         prg_banks    <= '0;
         chr_banks    <= '0;
         mirroring    <= '0;
         battery      <= 1'b0;
         error        <= 1'b0;
      end else begin
         load_q <= rom_loading;
         done   <= 1'b0;
         if (fall_evt) begin
            state        <= S_DRAIN;
            restart_pend <= 1'b0;
         end else if (start) begin
            state        <= S_HEADER;
            restart_pend <= 1'b0;
            busy         <= 1'b1;
            error        <= 1'b0;
            header_valid <= 1'b0;
            hdr_cnt      <= '0;
            trn_cnt      <= '0;
            byte_cnt     <= '0;
         end else if (restart_any) begin
            restart_pend <= 1'b1;
         end else begin
            case (state)
               S_HEADER: if (take) begin
                  hdr_cnt <= hdr_cnt + 4'd1;
                  case (hdr_cnt)
                     4'd0: if (rom_do != 8'h4E) begin error <= 1'b1; state <= S_DISCARD; end
                     4'd1: if (rom_do != 8'h45) begin error <= 1'b1; state <= S_DISCARD; end
                     4'd2: if (rom_do != 8'h53) begin error <= 1'b1; state <= S_DISCARD; end
                     4'd3: if (rom_do != 8'h1A) begin error <= 1'b1; state <= S_DISCARD; end
                     4'd4: prg_banks <= FW'(rom_do);
                     4'd5: chr_banks <= FW'(rom_do);
                     4'd6: begin
                        mirroring   <= {rom_do[3], rom_do[0]};
                        battery     <= rom_do[1];
                        trainer     <= rom_do[2];
                        mapper[3:0] <= rom_do[7:4];
                     end
                     4'd7: begin
                        mapper[7:4] <= rom_do[7:4];
`ifdef LOADER_NES20_EN
                        mapper[11:8] <= 4'd0;
                        nes2         <= (rom_do[3:2] == 2'b10);
`endif
                     end
`ifdef LOADER_NES20_EN
                     4'd8: if (nes2) mapper[11:8] <= rom_do[3:0];
                     4'd9: if (nes2) begin
                        prg_banks[11:8] <= rom_do[3:0];
                        chr_banks[11:8] <= rom_do[7:4];
                     end
`endif
                     4'd15: begin
                        header_valid <= 1'b1;
                        byte_cnt     <= '0;
                        state        <= trainer ? S_TRAINER : next_data(prg_banks, chr_banks);
                     end
                     default: ;
                  endcase
               end
               S_TRAINER: if (take) begin
                  trn_cnt <= trn_cnt + 9'd1;
                  if (trn_cnt == 9'd511) state <= next_data(prg_banks, chr_banks);
               end
               S_PRG: if (take) begin
                  // Bytes beyond 2 MB have no room in SDRAM below CHR.
                  if (!prg_in_range) error <= 1'b1;
                  if (byte_cnt == prg_last) begin
                     byte_cnt <= '0;
                     state    <= (chr_banks != '0) ? S_CHR : S_DISCARD;
                  end else begin
                     byte_cnt <= byte_cnt + BC_ONE;
                  end
               end
               S_CHR: if (take) begin
                  if (byte_cnt == chr_last) begin
                     byte_cnt <= '0;
                     state    <= S_DISCARD;
                  end else begin
                     byte_cnt <= byte_cnt + BC_ONE;
                  end
               end
               S_DRAIN: if (fifo_cnt == '0 && !bus.mem_req) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: ;
            endcase
         end
         if (overflow) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nes_rom_loader.sv
// Directed testbench for nes_rom_loader: clock/reset, stream driver tasks,
// an SDRAM responder with an expected-write queue, and a final report.
module tb_nes_rom_loader;
`ifdef LOADER_NES20_EN
   localparam int FW = 12;
`else
   localparam int FW = 8;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          rom_loading = 1'b0;
   logic [7:0]    rom_do = 8'h00;
   logic          rom_do_valid = 1'b0;
   logic          busy, done, header_valid, battery, error;
   logic [FW-1:0] mapper, prg_banks, chr_banks;
   logic [1:0]    mirroring;
   logic [2:0]    dbg_state;

   nes_rom_loader_if bus ();

   nes_rom_loader #(.FIFO_DEPTH(8), .CHR_BASE(22'h200000)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .rom_loading  (rom_loading),
      .rom_do       (rom_do),
      .rom_do_valid (rom_do_valid),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .header_valid (header_valid),
      .mapper       (mapper),
      .prg_banks    (prg_banks),
      .chr_banks    (chr_banks),
      .mirroring    (mirroring),
      .battery      (battery),
      .error        (error),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [29:0] exp_q[$];
   int          ack_delay = 0;
   bit          ack_hold  = 1'b0;
   bit          relaxed   = 1'b0;
   bit          first_wr  = 1'b1;
   logic [21:0] last_addr = '0;
   int          wr_cnt = 0;
   int          chr_wr_cnt = 0;
   int          req_cycles = 0;
   int          done_cnt = 0;
   logic        busy_q = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] pat(input int n, input logic [7:0] salt);
      logic [31:0] v;
      v = n;
      return v[7:0] ^ v[15:8] ^ salt;
   endfunction

   // SDRAM responder: acks each request after ack_delay cycles and scores it.
   initial begin
      int          wait_cnt;
      logic [29:0] expv;
      wait_cnt = 0;
      bus.mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         bus.mem_ack = 1'b0;
         if (bus.mem_req === 1'b1) req_cycles++;
         if (bus.mem_req === 1'b1 && !ack_hold) begin
            if (wait_cnt >= ack_delay) begin
               wait_cnt = 0;
               bus.mem_ack = 1'b1;
               wr_cnt++;
               if (bus.mem_addr >= 22'h200000) chr_wr_cnt++;
               if (relaxed) begin
                  check("wr_data_vs_addr", 32'(bus.mem_din), 32'(pat(int'(bus.mem_addr), 8'h00)));
                  check("wr_addr_increasing", 32'(first_wr || bus.mem_addr > last_addr), 1);
               end else begin
                  expv = (exp_q.size() != 0) ? exp_q.pop_front() : 30'h3FFFFFFF;
                  check("wr_addr_data", 32'({bus.mem_addr, bus.mem_din}), 32'(expv));
               end
               first_wr  = 1'b0;
               last_addr = bus.mem_addr;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   // done monitor: every done pulse must coincide with busy falling.
   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            check("done_with_busy_fall", 32'({busy_q, busy}), 32'(2'b10));
         end
         busy_q = busy;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rom_do = b;
      rom_do_valid = 1'b1;
      @(negedge clk);
      rom_do_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_header(input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                              input logic [7:0] b6, input logic [7:0] b7);
      logic [7:0] hb [16];
      hb = '{8'h4E, 8'h45, 8'h53, b3, b4, b5, b6, b7,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 15; i++) send_byte(hb[i], 0);
      check("hv_before_byte15", 32'(header_valid), 0);
      send_byte(hb[15], 0);
      check("hv_after_byte15", 32'(header_valid), 32'(b3 == 8'h1A));
   endtask

   task automatic start_load();
      @(negedge clk);
      rom_loading = 1'b1;
      @(negedge clk);
      check("start_busy", 32'(busy), 1);
      check("start_state_header", 32'(dbg_state), 1);
      check("start_error_clear", 32'(error), 0);
      check("start_hv_clear", 32'(header_valid), 0);
   endtask

   task automatic end_load(input int max_cycles);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      rom_loading = 1'b0;
      for (int i = 0; i < max_cycles && done_cnt == d0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("done_pulses_once", 32'(done_cnt - d0), 1);
      check("idle_not_busy", 32'(busy), 0);
      check("idle_state", 32'(dbg_state), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, c0, r0, d0;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(bus.mem_req), 0);
      check("rst_mem_addr", 32'(bus.mem_addr), 0);
      check("rst_mem_din", 32'(bus.mem_din), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_hv", 32'(header_valid), 0);
      check("rst_mapper", 32'(mapper), 0);
      check("rst_prg", 32'(prg_banks), 0);
      check("rst_chr", 32'(chr_banks), 0);
      check("rst_mirroring", 32'(mirroring), 0);
      check("rst_battery", 32'(battery), 0);
      check("rst_error", 32'(error), 0);
      check("rst_state", 32'(dbg_state), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // A: 1 PRG bank, CHR-RAM, vertical mirroring, 100 trailing bytes
      ack_delay = 0;
      w0 = wr_cnt;
      start_load();
      send_header(8'h1A, 8'h01, 8'h00, 8'h01, 8'h00);
      check("a_prg_banks", 32'(prg_banks), 1);
      check("a_chr_banks", 32'(chr_banks), 0);
      check("a_mirroring", 32'(mirroring), 32'(2'b01));
      check("a_mapper", 32'(mapper), 0);
      check("a_battery", 32'(battery), 0);
      for (int n = 0; n < 16384; n++) begin
         exp_q.push_back({22'(n), pat(n, 8'h00)});
         send_byte(pat(n, 8'h00), 0);
      end
      for (int n = 0; n < 100; n++) send_byte(pat(n, 8'h11), 0);
      end_load(200);
      check("a_all_written", 32'(exp_q.size()), 0);
      check("a_write_count", 32'(wr_cnt - w0), 16384);
      check("a_no_chr_writes", 32'(chr_wr_cnt), 0);
      check("a_error", 32'(error), 0);
      check("a_hv_holds", 32'(header_valid), 1);

      // B: CHR only, mapper 0x20; first and last CHR address via the queue
      w0 = wr_cnt;
      c0 = chr_wr_cnt;
      start_load();
      send_header(8'h1A, 8'h00, 8'h01, 8'h00, 8'h20);
      check("b_mapper", 32'(mapper), 32'h20);
      for (int n = 0; n < 8192; n++) begin
         exp_q.push_back({22'h200000 + 22'(n), pat(n, 8'h5A)});
         send_byte(pat(n, 8'h5A), 0);
      end
      for (int n = 0; n < 4; n++) send_byte(8'hE0 + 8'(n), 0);
      end_load(200);
      check("b_all_written", 32'(exp_q.size()), 0);
      check("b_chr_count", 32'(chr_wr_cnt - c0), 8192);
      check("b_write_count", 32'(wr_cnt - w0), 8192);
      check("b_error", 32'(error), 0);

      // C: trainer skipped, mapper 1, slow ack, truncated PRG
      ack_delay = 3;
      w0 = wr_cnt;
      start_load();
      send_header(8'h1A, 8'h01, 8'h00, 8'h14, 8'h00);
      check("c_mapper", 32'(mapper), 1);
      check("c_mirroring", 32'(mirroring), 0);
      for (int n = 0; n < 512; n++) send_byte(8'hAA, 0);
      for (int n = 0; n < 20; n++) begin
         exp_q.push_back({22'(n), pat(n, 8'hC3)});
         send_byte(pat(n, 8'hC3), 6);
      end
      end_load(400);
      check("c_all_written", 32'(exp_q.size()), 0);
      check("c_write_count", 32'(wr_cnt - w0), 20);
      check("c_error_truncated", 32'(error), 0);
      ack_delay = 0;

      // D: bad magic
      w0 = wr_cnt;
      r0 = req_cycles;
      start_load();
      send_header(8'h00, 8'h01, 8'h01, 8'h00, 8'h00);
      check("d_error", 32'(error), 1);
      for (int n = 0; n < 20; n++) send_byte(8'(n), 0);
      end_load(200);
      check("d_no_writes", 32'(wr_cnt - w0), 0);
      check("d_no_req", 32'(req_cycles - r0), 0);
      check("d_error_sticky", 32'(error), 1);
      check("d_hv", 32'(header_valid), 0);

      // E: 4-byte bursts against a slow memory overflow the FIFO
      relaxed   = 1'b1;
      first_wr  = 1'b1;
      ack_delay = 10;
      w0 = wr_cnt;
      start_load();
      send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            rom_do = pat(4 * k + j, 8'h00);
            rom_do_valid = 1'b1;
         end
         @(negedge clk);
         rom_do_valid = 1'b0;
         repeat (3) @(negedge clk);
      end
      check("e_error_overflow", 32'(error), 1);
      end_load(1000);
      check("e_some_dropped", 32'((wr_cnt - w0) < 24), 1);
      check("e_fifo_drained", 32'((wr_cnt - w0) > 8), 1);
      check("e_error_sticky", 32'(error), 1);
      relaxed   = 1'b0;
      ack_delay = 0;

      // F: restart mid-PRG with a request outstanding
      d0 = done_cnt;
      w0 = wr_cnt;
      ack_hold = 1'b1;
      start_load();
      send_header(8'h1A, 8'h01, 8'h00, 8'h00, 8'h00);
      exp_q.push_back({22'd0, pat(0, 8'h77)});
      for (int n = 0; n < 5; n++) send_byte(pat(n, 8'h77), 0);
      check("f_req_pending", 32'(bus.mem_req), 1);
      @(negedge clk);
      rom_loading = 1'b0;
      @(negedge clk);
      rom_loading = 1'b1;
      repeat (3) @(negedge clk);
      check("f_req_held", 32'(bus.mem_req), 1);
      check("f_addr_stable", 32'(bus.mem_addr), 0);
      check("f_din_stable", 32'(bus.mem_din), 32'(pat(0, 8'h77)));
      check("f_busy_wait", 32'(busy), 1);
      send_byte(8'hEE, 0);
      check("f_stray_no_error", 32'(error), 0);
      ack_hold = 1'b0;
      repeat (4) @(negedge clk);
      check("f_old_req_done", 32'(exp_q.size()), 0);
      check("f_state_header", 32'(dbg_state), 1);
      check("f_hv_clear", 32'(header_valid), 0);
      send_header(8'h1A, 8'h01, 8'h00, 8'h09, 8'h00);
      check("f_mirroring", 32'(mirroring), 32'(2'b11));
      for (int n = 0; n < 6; n++) begin
         exp_q.push_back({22'(n), pat(n, 8'h99)});
         send_byte(pat(n, 8'h99), 0);
      end
      end_load(200);
      check("f_all_written", 32'(exp_q.size()), 0);
      check("f_write_count", 32'(wr_cnt - w0), 7);
      check("f_single_done", 32'(done_cnt - d0), 1);
      check("f_error", 32'(error), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/nes_rom_loader.md
# nes_rom_loader

Byte-stream receiver for the ROM loading interface driven by the IO subsystem (`rom_loading`, `rom_do`, `rom_do_valid`). Parses the 16-byte iNES header, skips any trainer, and writes PRG and CHR bytes into SDRAM through a single-outstanding request/acknowledge write port. A small FIFO absorbs the 4-byte back-to-back bursts that the IO subsystem produces per firmware word. Parsed cartridge parameters are presented to the NES core.

## Interface
- `FIFO_DEPTH`, 8: byte FIFO entries; must be a power of two, ≥4.
- `CHR_BASE`, 22'h200000: SDRAM byte address of CHR byte 0.

Reset `resetn`, synchronous, active-low; clock `clk`.

- `clk` in 1: system clock, same domain as the IO subsystem.
- `resetn` in 1: synchronous active-low reset.
- `rom_loading` in 1: level; rise starts a load, fall ends it.
- `rom_do` in 8: stream byte.
- `rom_do_valid` in 1: 1-cycle strobe per byte.
- `mem_req` out 1: write request; held high until `mem_ack`.
- `mem_addr` out 22: byte address, stable while `mem_req` is high.
- `mem_din` out 8: write data, stable while `mem_req` is high.
- `mem_ack` in 1: 1-cycle pulse, write complete.
- `busy` out 1: load in progress (the NES core is held in reset).
- `done` out 1: 1-cycle pulse at load completion.
- `header_valid` out 1: header fields valid.
- `mapper` out 8: mapper number.
- `prg_banks` out 8: PRG size in 16 KB units.
- `chr_banks` out 8: CHR size in 8 KB units; 0 means CHR-RAM.
- `mirroring` out 2: {four_screen, vertical}.
- `battery` out 1: battery-backed PRG RAM.
- `error` out 1: sticky; set on bad magic, FIFO overflow, or PRG overrun.

## Operation
- States: IDLE, HEADER, TRAINER, PRG, CHR, DISCARD, DRAIN.
- IDLE → HEADER on a `rom_loading` rising edge. This clears `error`, `header_valid` and all counters, and sets `busy`.
- HEADER counts bytes 0–15.
  - Bytes 0–3 must be 4E 45 53 1A. On mismatch: `error`=1, go to DISCARD.
  - Byte 4 → `prg_banks`, byte 5 → `chr_banks`.
  - Byte 6 supplies `mirroring[0]`=b0, `battery`=b1, trainer=b2, `mirroring[1]`=b3, `mapper[3:0]`=b7:4.
  - Byte 7 supplies `mapper[7:4]`=b7:4.
  - After byte 15: `header_valid`=1; next state is TRAINER if trainer is set, else PRG.
- TRAINER drops 512 bytes, then goes to PRG.
- PRG: byte n is written to address n.
  - Length is `prg_banks`×16384.
  - Bytes with n ≥ 2 MB (`prg_banks` > 128) are dropped and set `error`.
  - When `prg_banks`=0, skip straight to CHR.
- CHR: byte n is written to `CHR_BASE`+n, length `chr_banks`×8192. When `chr_banks`=0, go to DISCARD.
- DISCARD: accept and drop all bytes.
- A `rom_loading` falling edge in any non-IDLE state → DRAIN.
- DRAIN: write out the remaining FIFO bytes that belong to PRG/CHR. When the FIFO is empty and no request is outstanding: pulse `done`, clear `busy`, go to IDLE. Header fields hold until the next load.
- Parsing is decided at FIFO push time (address tagged per entry). FIFO entries are {addr, data}; only writable bytes are pushed.
- FIFO full and push without a simultaneous pop: drop the byte, set `error`. Push and pop in the same cycle when full: allowed.
- Rising edge of `rom_loading` while not IDLE: restart.
  - An outstanding `mem_req` completes first (held until `mem_ack`).
  - The FIFO is flushed.
  - Bytes arriving during this wait are dropped without setting `error`.
- Truncated stream (fall before PRG/CHR is complete): `done` still pulses; `error` is unchanged.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_din`=0, `busy`=0, `done`=0, `header_valid`=0, `mapper`=0, `prg_banks`=0, `chr_banks`=0, `mirroring`=0, `battery`=0, `error`=0. State IDLE, FIFO empty.
- Reset mid-load drops `mem_req` immediately; the memory side tolerates an abandoned request.
- Edge detect on `rom_loading` uses one registered copy; state changes in the cycle after the edge is seen.
- `rom_do_valid` may assert on up to 4 consecutive cycles.
- Byte-to-FIFO: the byte is pushed in the cycle it is strobed. FIFO-to-`mem_req`: asserted one cycle after the entry is at the head.
- `mem_req` falls in the cycle after `mem_ack`. The next request may assert in that same following cycle, so the minimum spacing is 2 cycles per byte.
- `header_valid` rises the cycle after byte 15 is strobed.
- `done` is asserted exactly 1 cycle and coincides with `busy` falling.

## Configuration
- `LOADER_NES20_EN` defined: when byte 7[3:2]=2'b10 (NES 2.0), byte 8[3:0] extends the mapper number and `mapper` widens to 12 bits. Byte 9[3:0] and [7:4] become PRG and CHR bank MSBs, widening `prg_banks` and `chr_banks` to 12 bits. Size limits and `error` rules are unchanged.
- Not defined: bytes 8–15 are ignored and the port widths are as listed.

## Test plan
- Header 4E 45 53 1A 02 01 01 00 + 8×00, then 32768 PRG + 8192 CHR bytes, with `mem_ack` 3 cycles after each request → PRG at 0x000000–0x007FFF and CHR at 0x200000–0x201FFF. `mapper`=0, `mirroring`=01, `done` pulses once, `error`=0.
- Byte 6=0x14 (trainer, mapper 1) → the 512 bytes after the header are not written; first PRG byte goes to 0x000000; `mapper`=1.
- Bad magic 4E 45 53 00 → `error`=1, zero `mem_req`, `done` still pulses after `rom_loading` falls.
- 4-byte bursts every 4 cycles with `mem_ack` delayed 10 cycles → FIFO overflows, `error`=1, the dropped bytes are never written.
- `chr_banks`=0 with 100 extra bytes after PRG → no writes at or above `CHR_BASE`.
- Restart via a `rom_loading` rising edge mid-PRG with a request outstanding → `mem_req` holds until `mem_ack`, then the new header is parsed cleanly.
